// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX arbiter and RX block: FSM state encoding, default frame width.
// Pure declarations and a combinational helper; no timing, no flow control.
package uart_pkg;

  localparam int UART_DBITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } uart_arb_state_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters; 0 when empty.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first request above ptr (wrapping), via the double-width mask trick.
// Purely combinational, zero latency; no backpressure, caller decides when to sample gnt.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any_req
);

  logic [NREQ-1:0]   w_mask;
  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_dbl_gnt;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (i > int'(ptr));
    end
  end

  // Low half holds requests above ptr, high half the full vector for wraparound.
  assign w_dbl     = {req, req & w_mask};
  assign w_dbl_gnt = w_dbl & (~w_dbl + {{(2*NREQ-1){1'b0}}, 1'b1});
  assign gnt       = w_dbl_gnt[NREQ-1:0] | w_dbl_gnt[2*NREQ-1:NREQ];
  assign any_req   = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NREQ byte sources with burst lock; watchdog under UART_TX_ARB_TIMEOUT_EN.
// req_ready 1 cycle after req_valid in IDLE, tx_start 1 later; holds each owner until tx_done, then re-arbitrates.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DBITS      = UART_DBITS,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*DBITS-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  tx_start,
  output logic [DBITS-1:0]      tx_din,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || GAP_CYCLES < 0 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  uart_arb_state_t  r_state;
  logic [NREQ-1:0]  r_grant;
  logic [PW-1:0]    r_gidx;
  logic [PW-1:0]    r_ptr;
  logic             r_lock;
  logic             r_tx_start;
  logic [DBITS-1:0] r_tx_din;
  logic [BW-1:0]    r_burst;
  logic [GW-1:0]    r_gap;

  logic [NREQ-1:0]  w_arb_gnt;
  logic             w_any;
  logic [PW-1:0]    w_arb_idx;
  logic [DBITS-1:0] w_sel_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_to;
  logic          r_err;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_arb_gnt),
    .any_req (w_any)
  );

  assign w_arb_idx  = PW'(onehot_to_idx(8'(w_arb_gnt)));
  assign w_sel_data = req_data[r_gidx*DBITS +: DBITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_ptr      <= PW'(NREQ - 1);
      r_lock     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_din   <= '0;
      r_burst    <= '0;
      r_gap      <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_to       <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_arb_gnt;
            r_gidx  <= w_arb_idx;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_valid[r_gidx]) begin
            r_tx_din   <= w_sel_data;
            r_lock     <= req_lock[r_gidx];
            r_tx_start <= 1'b1;
            r_state    <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_to       <= '0;
`endif
          end else begin
            // Owner dropped valid before the handshake: release without moving the pointer.
            r_grant <= '0;
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (tx_done && !r_tx_start) begin
            r_ptr <= r_gidx;
            if (r_lock && (r_burst < BURST_LAST)) begin
              r_burst <= r_burst + BW'(1);
              r_state <= ISSUE;
            end else begin
              r_burst <= '0;
              r_grant <= '0;
              r_gap   <= '0;
              r_state <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (r_to == TO_LAST) begin
            r_err   <= 1'b1;
            r_burst <= '0;
            r_grant <= '0;
            r_ptr   <= r_gidx;
            r_state <= IDLE;
          end else begin
            r_to <= r_to + TW'(1);
          end
`endif
        end
        GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ISSUE) ? r_grant : '0;
  assign grant     = r_grant;
  assign tx_start  = r_tx_start;
  assign tx_din    = r_tx_din;
  assign busy      = (r_state != IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a transmitter model drive two instances (no gap, 5-cycle gap).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [31:0] req_data;
  logic        tx_done;

  logic [3:0] d_ready, d_grant, g_ready, g_grant;
  logic       d_start, d_busy, d_err, g_start, g_busy, g_err;
  logic [7:0] d_din, g_din;

  bit         use_gap;
  logic [3:0] m_ready, m_grant;
  logic       m_start, m_busy, m_err;
  logic [7:0] m_din;

  int n_total, n_bad, inv_err, cyc;
  int tx_cnt, tx_dly, done_cyc;
  bit tx_auto;
  logic [7:0] held_din;
  logic [3:0] pend, lock_en;
  logic [7:0] qbuf [4][32];
  int qhead [4];
  int qtail [4];
  logic [7:0] log_dat [64];
  int log_req [64];
  int log_cyc [64];
  int n_log;

  uart_tx_arbiter #(.NREQ(4), .DBITS(8), .MAX_BURST(16), .GAP_CYCLES(0), .TIMEOUT(100)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock), .req_data(req_data),
    .req_ready(d_ready), .grant(d_grant), .tx_start(d_start), .tx_din(d_din), .tx_done(tx_done),
    .busy(d_busy), .err_timeout(d_err));

  uart_tx_arbiter #(.NREQ(4), .DBITS(8), .MAX_BURST(16), .GAP_CYCLES(5), .TIMEOUT(100)) u_gap (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock), .req_data(req_data),
    .req_ready(g_ready), .grant(g_grant), .tx_start(g_start), .tx_din(g_din), .tx_done(tx_done),
    .busy(g_busy), .err_timeout(g_err));

  assign m_ready = use_gap ? g_ready : d_ready;
  assign m_grant = use_gap ? g_grant : d_grant;
  assign m_start = use_gap ? g_start : d_start;
  assign m_busy  = use_gap ? g_busy  : d_busy;
  assign m_err   = use_gap ? g_err   : d_err;
  assign m_din   = use_gap ? g_din   : d_din;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int oh2i(input logic [3:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic push(input int i, input logic [7:0] dat);
    qbuf[i][qtail[i]] = dat;
    qtail[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (qhead[i] < qtail[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = qbuf[i][qhead[i]];
        req_lock[i] = lock_en[i] && (qtail[i] - qhead[i] > 1);
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_lock[i] = 1'b0;
      end
    end
  endtask

  // One clock: transmitter model, requester pops after accepted handshakes, logging.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        done_cyc = cyc;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        qhead[i]++;
        pend[i] = 1'b0;
      end
    end
    drive();
    if (m_start) begin
      if (n_log < 64) begin
        log_dat[n_log] = m_din;
        log_req[n_log] = oh2i(m_grant);
        log_cyc[n_log] = cyc;
        n_log++;
      end
      held_din = m_din;
      if (tx_auto) tx_cnt = tx_dly;
    end else if (tx_cnt > 0 && m_din !== held_din) begin
      inv_err++;
    end
    for (int i = 0; i < 4; i++) if (m_ready[i]) pend[i] = 1'b1;
    if ((m_ready & ~m_grant) != 4'd0) inv_err++;
    if ((m_grant & (m_grant - 4'd1)) != 4'd0) inv_err++;
  endtask

  task automatic clear_bench();
    for (int i = 0; i < 4; i++) begin
      qhead[i] = 0;
      qtail[i] = 0;
    end
    pend = 4'd0;
    lock_en = 4'd0;
    n_log = 0;
    tx_cnt = 0;
    tx_done = 1'b0;
    tx_auto = 1'b1;
    tx_dly = 4;
    drive();
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    clear_bench();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_bench();
    tick();
    n_total++; if (m_grant !== 4'd0) begin n_bad++; $display("FAIL reset_grant got=%h exp=0", m_grant); end
    n_total++; if (m_ready !== 4'd0) begin n_bad++; $display("FAIL reset_ready got=%h exp=0", m_ready); end
    n_total++; if (m_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start got=%b exp=0", m_start); end
    n_total++; if (m_din !== 8'd0) begin n_bad++; $display("FAIL reset_tx_din got=%h exp=0", m_din); end
    n_total++; if (m_busy !== 1'b0 || g_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b/%b exp=0", m_busy, g_busy); end
    n_total++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", m_err); end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_total++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%b exp=0", m_busy); end
  endtask

  task automatic test_single();
    int t0, rdy_c, st_c, dn, fall;
    logic [3:0] rdy_v;
    logic [7:0] din;
    reset_dut();
    tx_dly = 160;
    push(2, 8'hA5);
    tick();
    t0 = cyc; rdy_c = -1; st_c = -1; dn = -1; fall = -1; rdy_v = 4'd0; din = 8'd0;
    for (int k = 0; k < 400 && fall < 0; k++) begin
      tick();
      if (rdy_c < 0 && m_ready != 4'd0) begin rdy_c = cyc; rdy_v = m_ready; end
      if (st_c < 0 && m_start) begin st_c = cyc; din = m_din; end
      if (st_c >= 0 && dn < 0 && tx_done) dn = cyc;
      if (dn >= 0 && cyc > dn && fall < 0 && !m_busy) fall = cyc;
    end
    n_total++; if (rdy_c !== t0 + 1) begin n_bad++; $display("FAIL single_ready_cycle got=%0d exp=%0d", rdy_c, t0 + 1); end
    n_total++; if (rdy_v !== 4'b0100) begin n_bad++; $display("FAIL single_ready_value got=%b exp=0100", rdy_v); end
    n_total++; if (st_c !== t0 + 2) begin n_bad++; $display("FAIL single_start_cycle got=%0d exp=%0d", st_c, t0 + 2); end
    n_total++; if (din !== 8'hA5) begin n_bad++; $display("FAIL single_tx_din got=%h exp=a5", din); end
    n_total++; if (dn !== st_c + 160) begin n_bad++; $display("FAIL single_done_cycle got=%0d exp=%0d", dn, st_c + 160); end
    n_total++; if (fall !== dn + 1) begin n_bad++; $display("FAIL single_busy_fall got=%0d exp=%0d", fall, dn + 1); end
  endtask

  task automatic test_round_robin();
    int exp_r [5];
    logic [7:0] exp_d [5];
    exp_r = '{0, 1, 2, 3, 0};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    reset_dut();
    tx_dly = 3;
    for (int i = 0; i < 4; i++) begin
      push(i, 8'h10 + 8'(i));
      push(i, 8'h20 + 8'(i));
    end
    for (int k = 0; k < 200 && n_log < 5; k++) tick();
    for (int k = 0; k < 5; k++) begin
      n_total++; if (log_req[k] !== exp_r[k]) begin n_bad++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, log_req[k], exp_r[k]); end
      n_total++; if (log_dat[k] !== exp_d[k]) begin n_bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, log_dat[k], exp_d[k]); end
    end
  endtask

  task automatic test_burst_lock();
    int er;
    logic [7:0] ed;
    reset_dut();
    tx_dly = 4;
    lock_en[1] = 1'b1;
    for (int k = 0; k < 20; k++) push(1, 8'h40 + 8'(k));
    push(3, 8'h77);
    for (int k = 0; k < 600 && n_log < 21; k++) tick();
    n_total++; if (n_log !== 21) begin n_bad++; $display("FAIL burst_count got=%0d exp=21", n_log); end
    for (int k = 0; k < 21; k++) begin
      if (k < 16) begin er = 1; ed = 8'h40 + 8'(k); end
      else if (k == 16) begin er = 3; ed = 8'h77; end
      else begin er = 1; ed = 8'h40 + 8'(k - 1); end
      n_total++; if (log_req[k] !== er || log_dat[k] !== ed) begin
        n_bad++; $display("FAIL burst_entry[%0d] got=%0d/%h exp=%0d/%h", k, log_req[k], log_dat[k], er, ed);
      end
    end
    n_total++; if (log_cyc[1] - log_cyc[0] !== tx_dly + 2) begin n_bad++; $display("FAIL burst_b2b_spacing got=%0d exp=%0d", log_cyc[1] - log_cyc[0], tx_dly + 2); end
    n_total++; if (log_cyc[16] - log_cyc[15] !== tx_dly + 3) begin n_bad++; $display("FAIL burst_release_spacing got=%0d exp=%0d", log_cyc[16] - log_cyc[15], tx_dly + 3); end
  endtask

  task automatic test_gap();
    int d, gapc, gc;
    use_gap = 1'b1;
    reset_dut();
    tx_dly = 4;
    push(0, 8'h31);
    push(1, 8'h32);
    d = -1; gapc = 0; gc = -1;
    for (int k = 0; k < 100 && d < 0; k++) begin
      tick();
      if (tx_done) d = cyc;
    end
    for (int k = 0; k < 50 && gc < 0; k++) begin
      tick();
      if (m_grant != 4'd0) gc = cyc;
      else if (m_busy) gapc++;
    end
    n_total++; if (gapc !== 5) begin n_bad++; $display("FAIL gap_cycles got=%0d exp=5", gapc); end
    n_total++; if (gc !== d + 7) begin n_bad++; $display("FAIL gap_next_grant got=%0d exp=%0d", gc, d + 7); end
    n_total++; if (m_grant !== 4'b0010) begin n_bad++; $display("FAIL gap_next_owner got=%b exp=0010", m_grant); end
    use_gap = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    tx_dly = 1000;
    push(2, 8'h66);
    for (int k = 0; k < 20 && n_log < 1; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    n_total++; if (m_busy !== 1'b1 || m_grant !== 4'b0100) begin n_bad++; $display("FAIL mid_in_wait got=%b/%b exp=1/0100", m_busy, m_grant); end
    #2;
    reset = 1'b0;
    #1;
    n_total++; if (m_grant !== 4'd0) begin n_bad++; $display("FAIL mid_grant got=%b exp=0", m_grant); end
    n_total++; if (m_ready !== 4'd0 || m_start !== 1'b0) begin n_bad++; $display("FAIL mid_ready_start got=%b/%b exp=0", m_ready, m_start); end
    n_total++; if (m_din !== 8'd0) begin n_bad++; $display("FAIL mid_tx_din got=%h exp=0", m_din); end
    n_total++; if (m_busy !== 1'b0 || m_err !== 1'b0) begin n_bad++; $display("FAIL mid_busy_err got=%b/%b exp=0", m_busy, m_err); end
    clear_bench();
    push(3, 8'h55);
    push(2, 8'h67);
    push(0, 8'h01);
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 20 && n_log < 1; k++) tick();
    n_total++; if (log_req[0] !== 0 || log_dat[0] !== 8'h01) begin n_bad++; $display("FAIL mid_first_after_reset got=%0d/%h exp=0/01", log_req[0], log_dat[0]); end
  endtask

  task automatic test_timeout();
    int s;
    reset_dut();
    tx_auto = 1'b0;
    push(0, 8'h11);
    push(1, 8'h22);
    for (int k = 0; k < 20 && n_log < 1; k++) tick();
    s = log_cyc[0];
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int ec;
      logic [3:0] eg;
      logic eb, e2;
      ec = -1; eg = 4'hf; eb = 1'b1;
      for (int k = 0; k < 300 && ec < 0; k++) begin
        tick();
        if (m_err) begin ec = cyc; eg = m_grant; eb = m_busy; end
      end
      tick();
      e2 = m_err;
      n_total++; if (ec !== s + 100) begin n_bad++; $display("FAIL timeout_cycle got=%0d exp=%0d", ec, s + 100); end
      n_total++; if (eg !== 4'd0 || eb !== 1'b0) begin n_bad++; $display("FAIL timeout_release got=%b/%b exp=0/0", eg, eb); end
      n_total++; if (e2 !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse_width got=%b exp=0", e2); end
      tx_auto = 1'b1;
      for (int k = 0; k < 40 && n_log < 2; k++) tick();
      n_total++; if (log_req[1] !== 1 || log_dat[1] !== 8'h22) begin n_bad++; $display("FAIL timeout_next got=%0d/%h exp=1/22", log_req[1], log_dat[1]); end
    end
`else
    begin
      int errs;
      errs = 0;
      for (int k = 0; k < 300; k++) begin
        tick();
        if (m_err) errs++;
      end
      n_total++; if (errs !== 0) begin n_bad++; $display("FAIL no_timeout_err got=%0d exp=0", errs); end
      n_total++; if (m_busy !== 1'b1 || m_grant !== 4'b0001) begin n_bad++; $display("FAIL no_timeout_hold got=%b/%b exp=1/0001", m_busy, m_grant); end
    end
`endif
  endtask

  task automatic test_invariants();
    n_total++; if (inv_err !== 0) begin n_bad++; $display("FAIL invariants got=%0d exp=0", inv_err); end
  endtask

  initial begin
    n_total = 0; n_bad = 0; inv_err = 0; cyc = 0; done_cyc = 0;
    use_gap = 1'b0; held_din = 8'd0;
    req_valid = 4'd0; req_lock = 4'd0; req_data = 32'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_lock();
    test_gap();
    test_reset_mid();
    test_timeout();
    test_invariants();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
